// File: rtl/matrix_bram_arbiter.sv
// -----------------------------------------------------------------------------
// matrix_bram_arbiter
//
// Shares one single-port matrix-store BRAM among NUM_REQ clients (scanner,
// reader, input writer, compute engine). Round-robin grant with burst
// ownership, an optional hold limit that preempts a long-running owner when
// someone else is waiting, and per-requester read-valid tracking across the
// BRAM read latency.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   req[i]              requester i wants the port; held high for its burst
//   req_we[i]           write enable of requester i (used only while owner)
//   req_addr, req_wdata flattened per-requester address / write data
//   gnt                 registered one-hot grant
//   preempt             one-cycle pulse to an owner revoked by the hold limit
//   rvalid              read data valid, one-hot by requester
//   rdata               broadcast read data (straight from bram_rdata)
//   bram_*              BRAM primitive port
//   busy                a grant is held or a read is still in flight
// -----------------------------------------------------------------------------
module matrix_bram_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_HOLD   = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               preempt,
    output logic [NUM_REQ-1:0]               rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             bram_en,
    output logic                             bram_we,
    output logic [ADDR_WIDTH-1:0]            bram_addr,
    output logic [DATA_WIDTH-1:0]            bram_wdata,
    input  logic [DATA_WIDTH-1:0]            bram_rdata,
    output logic                             busy
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    // Last owned-cycle count before the hold limit bites; 0 when unlimited.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam bit                HOLD_EN   = (MAX_HOLD != 0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     preempt_q, preempt_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0]     tag_q [RD_LATENCY];
    logic [NUM_REQ-1:0]     tag_d [RD_LATENCY];

    // Owner-side datapath
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_sel;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata_sel;
    logic [ADDR_WIDTH-1:0]  owner_addr;
    logic [DATA_WIDTH-1:0]  owner_wdata;
    logic                   owner_req;
    logic                   owner_we;
    logic [IDX_W-1:0]       owner_idx;
    logic [IDX_W-1:0]       owner_inc;
    logic                   access;
    logic [NUM_REQ-1:0]     rd_tag;
    logic                   any_tag;

    // Arbitration
    logic [IDX_W-1:0]       arb_base;
    logic [NUM_REQ-1:0]     arb_mask;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic                   other_pending;
    logic                   hold_hit;

    // Zero every non-owner slice so the owner's fields fall out of an OR.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
            assign addr_sel[gi*ADDR_WIDTH +: ADDR_WIDTH] =
                gnt_q[gi] ? req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] : '0;
            assign wdata_sel[gi*DATA_WIDTH +: DATA_WIDTH] =
                gnt_q[gi] ? req_wdata[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    endgenerate

    always_comb begin
        owner_addr  = '0;
        owner_wdata = '0;
        owner_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_addr  = owner_addr | addr_sel[i*ADDR_WIDTH +: ADDR_WIDTH];
            owner_wdata = owner_wdata | wdata_sel[i*DATA_WIDTH +: DATA_WIDTH];
            if (gnt_q[i]) begin
                owner_idx = IDX_W'(i);
            end
        end
        owner_req     = |(req & gnt_q);
        owner_we      = |(req_we & gnt_q);
        owner_inc     = (owner_idx == LAST_IDX) ? '0 : owner_idx + IDX_W'(1);
        other_pending = |(req & ~gnt_q);
        hold_hit      = HOLD_EN && (hold_cnt_q == HOLD_LAST) && other_pending;
    end

    // Round-robin search. While owned, the search starts just past the owner
    // and excludes it, which is what a release or preemption hands over to.
    always_comb begin
        arb_base   = (state_q == OWNED) ? owner_inc : rr_ptr_q;
        arb_mask   = (state_q == OWNED) ? (req & ~gnt_q) : req;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_valid && arb_mask[i] && (IDX_W'(i) >= arb_base)) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
        // Wrap-around pass for indices below the base.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_valid && arb_mask[i]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            preempt_q  <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            preempt_q  <= preempt_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            for (int s = 0; s < RD_LATENCY; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        preempt_d  = '0;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = OWNED;
                    gnt_d      = NUM_REQ'(1) << pick_idx;
                    hold_cnt_d = '0;
                end
            end
            OWNED: begin
                if (!owner_req || hold_hit) begin
                    // Release or preemption: hand over without an idle cycle
                    // when anyone else is waiting.
                    rr_ptr_d   = owner_inc;
                    hold_cnt_d = '0;
                    preempt_d  = owner_req ? gnt_q : '0;
                    if (pick_valid) begin
                        gnt_d = NUM_REQ'(1) << pick_idx;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Output logic: the port follows the owner combinationally.
    always_comb begin
        access     = (state_q == OWNED) && owner_req;
        bram_en    = access;
        bram_we    = access && owner_we;
        bram_addr  = access ? owner_addr : '0;
        bram_wdata = access ? owner_wdata : '0;
        rd_tag     = (access && !owner_we) ? gnt_q : '0;
    end

    // Read tag shift register: the tag stays with the read even if the
    // requester loses its grant before the data returns.
    always_comb begin
        tag_d[0] = rd_tag;
        for (int s = 1; s < RD_LATENCY; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        any_tag = 1'b0;
        for (int s = 0; s < RD_LATENCY; s++) begin
            any_tag = any_tag | (|tag_q[s]);
        end
    end

    assign gnt     = gnt_q;
    assign preempt = preempt_q;
    assign rvalid  = tag_q[RD_LATENCY-1];
    assign rdata   = bram_rdata;
    assign busy    = (state_q == OWNED) || any_tag;

endmodule

// File: tb/tb_matrix_bram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_matrix_bram_arbiter
//
// Drives the arbiter with directed scenarios followed by randomized bursts.
// A behavioural model (owner index, round-robin pointer, hold count and a
// queue of outstanding reads with due cycles) predicts every output; it is
// compared on each falling edge. Directed scenarios also carry hand-computed
// expectations. A simple BRAM model with the configured read latency sits on
// the memory port.
// -----------------------------------------------------------------------------
module tb_matrix_bram_arbiter;

    localparam int N  = 4;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int L  = 3;
    localparam int MH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N-1:0]      req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      gnt;
    logic [N-1:0]      preempt;
    logic [N-1:0]      rvalid;
    logic [DW-1:0]     rdata;
    logic              bram_en;
    logic              bram_we;
    logic [AW-1:0]     bram_addr;
    logic [DW-1:0]     bram_wdata;
    logic [DW-1:0]     bram_rdata;
    logic              busy;

    int total = 0;
    int bad   = 0;

    matrix_bram_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (L),
        .MAX_HOLD   (MH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .preempt    (preempt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- BRAM model ----------------
    logic [DW-1:0] bram_mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe  [L];

    always @(posedge clk) begin
        if (bram_en && bram_we) bram_mem[bram_addr] <= bram_wdata;
        rd_pipe[0] <= bram_mem[bram_addr];
        for (int s = 1; s < L; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign bram_rdata = rd_pipe[L-1];

    function automatic logic [DW-1:0] word(input int a);
        return 32'h5A00_0000 + 32'(a) * 32'd7;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } pend_t;

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    pend_t         pend [$];
    int            m_owner = -1;
    int            m_rr    = 0;
    int            m_hold  = 0;
    int            m_cyc   = 0;
    logic [N-1:0]  m_pre   = '0;

    // First requester with a set bit, searching upward from base with wrap.
    function automatic int pick(input logic [N-1:0] mask, input int base);
        for (int k = 0; k < N; k++) begin
            if (mask[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0]  exp_gnt, exp_rv, others, nxt_pre;
        logic [DW-1:0] exp_rd;
        logic          acc;
        int            a;
        if (rst) begin
            pend.delete();
            m_owner = -1;
            m_rr    = 0;
            m_hold  = 0;
            m_pre   = '0;
        end
        acc     = (m_owner >= 0) && req[m_owner];
        exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        exp_rv  = '0;
        exp_rd  = '0;
        foreach (pend[p]) begin
            if (pend[p].due == m_cyc) begin
                exp_rv[pend[p].id] = 1'b1;
                exp_rd = pend[p].data;
            end
        end
        chk("cmp_gnt", gnt, exp_gnt);
        chk("cmp_preempt", preempt, m_pre);
        chk("cmp_rvalid", rvalid, exp_rv);
        if (exp_rv != '0) chk("cmp_rdata", rdata, exp_rd);
        chk("cmp_busy", busy, (m_owner >= 0) || (pend.size() > 0));
        chk("cmp_en", bram_en, acc);
        chk("cmp_we", bram_we, acc && req_we[m_owner]);
        chk("cmp_addr", bram_addr, acc ? req_addr[m_owner*AW +: AW] : '0);
        chk("cmp_wdata", bram_wdata, acc ? req_wdata[m_owner*DW +: DW] : '0);
        while (pend.size() > 0 && pend[0].due <= m_cyc) void'(pend.pop_front());

        if (!rst) begin
            if (acc) begin
                a = int'(req_addr[m_owner*AW +: AW]);
                if (req_we[m_owner]) ref_mem[a] = req_wdata[m_owner*DW +: DW];
                else pend.push_back('{m_cyc + L, m_owner, ref_mem[a]});
            end
            others  = req;
            nxt_pre = '0;
            if (m_owner >= 0) others[m_owner] = 1'b0;
            if (m_owner < 0) begin
                if (req != '0) begin
                    m_owner = pick(req, m_rr);
                    m_hold  = 0;
                end
            end else if (!req[m_owner] || (MH != 0 && m_hold >= MH - 1 && others != '0)) begin
                if (req[m_owner]) nxt_pre[m_owner] = 1'b1;
                m_rr    = (m_owner + 1) % N;
                m_owner = pick(others, m_rr);
                m_hold  = 0;
            end else if (MH != 0 && m_hold < MH - 1) begin
                m_hold++;
            end
            m_pre = nxt_pre;
            m_cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int i, input logic r, input logic we, input int a,
                       input logic [DW-1:0] wd);
        req[i]                = r;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = AW'(a);
        req_wdata[i*DW +: DW] = wd;
    endtask

    task automatic clear_all();
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_all();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    logic [N-1:0] b_req [11] = '{4'h5, 4'h5, 4'h5, 4'h4, 4'h5, 4'h5, 4'h5, 4'h1, 4'h0, 4'h0, 4'h0};
    logic [N-1:0] b_gnt [11] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h1, 4'h0, 4'h0};

    int burst [N];
    int gap   [N];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            bram_mem[i] = word(i);
            ref_mem[i]  = word(i);
        end
        for (int s = 0; s < L; s++) rd_pipe[s] = '0;
        rst = 1'b1;
        clear_all();
        repeat (3) next_cycle();
        rst = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_en", bram_en, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_preempt", preempt, 0);
        next_cycle();

        // Single reader: requester 1 reads addresses 0..3.
        for (int k = 0; k < 10; k++) begin
            drv(1, k <= 4, 1'b0, (k == 0 || k > 4) ? 0 : k - 1, '0);
            #1;
            chk("A_gnt", gnt, (k >= 1 && k <= 5) ? 4'b0010 : 4'b0000);
            chk("A_en", bram_en, k >= 1 && k <= 4);
            if (k >= 1 && k <= 4) chk("A_addr", bram_addr, k - 1);
            chk("A_rvalid", rvalid, (k >= 4 && k <= 7) ? 4'b0010 : 4'b0000);
            if (k >= 4 && k <= 7) chk("A_rdata", rdata, word(k - 4));
            chk("A_busy", busy, k >= 1 && k <= 7);
            next_cycle();
        end

        // Contention straight after reset: 0 first, then 2, then 0 again.
        do_reset();
        for (int k = 0; k < 11; k++) begin
            for (int i = 0; i < N; i++) drv(i, b_req[k][i], 1'b0, 40 + i, '0);
            #1;
            chk("B_gnt", gnt, b_gnt[k]);
            next_cycle();
        end

        // Write then read back, requester 3.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drv(3, (k <= 1) || (k == 3) || (k == 4), k <= 1, 100, 32'hDEAD_BEEF);
            #1;
            chk("C_gnt", gnt, (k == 1 || k == 2 || k == 4 || k == 5) ? 4'b1000 : 4'b0000);
            if (k == 1) begin
                chk("C_wr_we", bram_we, 1);
                chk("C_wr_addr", bram_addr, 100);
                chk("C_wr_data", bram_wdata, 32'hDEAD_BEEF);
            end
            if (k == 4) begin
                chk("C_rd_en", bram_en, 1);
                chk("C_rd_we", bram_we, 0);
            end
            chk("C_rvalid", rvalid, (k == 7) ? 4'b1000 : 4'b0000);
            if (k == 7) chk("C_rdata", rdata, 32'hDEAD_BEEF);
            next_cycle();
        end

        // Hold limit: requester 0 is preempted after 8 accesses.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            drv(0, k <= 12, 1'b0, 200 + ((k > 0) ? k - 1 : 0), '0);
            drv(1, k >= 2 && k <= 12, 1'b0, 300 + k, '0);
            #1;
            chk("D_gnt", gnt, (k >= 1 && k <= 8) ? 4'b0001 :
                              (k >= 9 && k <= 13) ? 4'b0010 : 4'b0000);
            chk("D_preempt", preempt, (k == 9) ? 4'b0001 : 4'b0000);
            if (k == 8) chk("D_last_addr", bram_addr, 207);
            chk("D_rvalid", rvalid, (k >= 4 && k <= 11) ? 4'b0001 :
                                    (k >= 12 && k <= 15) ? 4'b0010 : 4'b0000);
            if (k >= 4 && k <= 11) chk("D_rdata0", rdata, word(200 + k - 4));
            if (k >= 12 && k <= 15) chk("D_rdata1", rdata, word(300 + k - 3));
            next_cycle();
        end

        // Asynchronous reset with reads in flight.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drv(2, 1'b1, 1'b0, 50 + k, '0);
            if (k < 3) next_cycle();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("F_gnt", gnt, 0);
        chk("F_busy", busy, 0);
        chk("F_en", bram_en, 0);
        chk("F_rvalid", rvalid, 0);
        clear_all();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("F_post_rvalid", rvalid, 0);
            chk("F_post_busy", busy, 0);
            next_cycle();
        end

        // Randomized bursts.
        for (int i = 0; i < N; i++) begin
            burst[i] = 0;
            gap[i]   = 0;
        end
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 699) == 0) begin
                rst = 1'b1;
                clear_all();
                for (int i = 0; i < N; i++) begin
                    burst[i] = 0;
                    gap[i]   = 0;
                end
                next_cycle();
                rst = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    burst[i]--;
                    if (burst[i] <= 0) begin
                        req[i] = 1'b0;
                        gap[i] = int'($urandom_range(0, 4));
                    end
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i]   = 1'b1;
                    burst[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 24))
                                                           : int'($urandom_range(1, 6));
                end
                req_we[i]             = ($urandom_range(0, 2) == 0);
                req_addr[i*AW +: AW]  = AW'($urandom_range(0, 31));
                req_wdata[i*DW +: DW] = $urandom;
            end
            next_cycle();
        end
        clear_all();
        repeat (L + 3) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/matrix_bram_arbiter.md
# matrix_bram_arbiter

Shares the single-port matrix storage BRAM among up to NUM_REQ requesters: matrix scanner, matrix reader, input writer, compute engine. Round-robin grant with burst ownership (the owner keeps the port while its request stays high), an optional hold limit against starvation, and per-requester read-data-valid tracking across the BRAM read latency. It replaces the priority address mux in the operation selector and sits between all matrix-store clients and the BRAM primitive.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_WIDTH, 14: BRAM address width.
- DATA_WIDTH, 32: BRAM data width.
- RD_LATENCY, 1: BRAM read latency in cycles (1..3).
- MAX_HOLD, 0: maximum consecutive owned cycles; 0 = unlimited.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester access request; held high for the whole burst.
- req_we  in  NUM_REQ  per-requester write enable, qualified by grant.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- gnt  out  NUM_REQ  registered one-hot grant.
- preempt  out  NUM_REQ  one-cycle pulse to a requester whose grant was revoked by MAX_HOLD.
- rvalid  out  NUM_REQ  read data valid for requester i.
- rdata  out  DATA_WIDTH  broadcast read data, equal to bram_rdata.
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_wdata  out  DATA_WIDTH  BRAM write data.
- bram_rdata  in  DATA_WIDTH  BRAM read data.
- busy  out  1  high while any grant is held or any read is in flight.

## Operation
- FSM states:
  - IDLE: no grant.
  - OWNED: exactly one gnt bit high.
- IDLE, any req high: pick the first requester with req high, searching from rr_ptr upward with wrap (NUM_REQ-1 → 0). Set its gnt at the next edge and move to OWNED.
- OWNED: each cycle that owner i has req[i]=1, the port is driven combinationally from requester i:
  - bram_en=1, bram_we=req_we[i], bram_addr and bram_wdata from slice i.
  - A read (we=0) is issued that cycle.
- Release: in any cycle where the owner's req is low, no access is issued. gnt clears at the next edge, and rr_ptr = owner+1 (mod NUM_REQ).
  - Arbitration in that same cycle excludes the releasing requester.
  - If another req is high, its gnt rises at that same edge (back-to-back handover, no idle cycle). Otherwise return to IDLE.
- Hold limit: hold_cnt counts owned cycles and clears on every grant change.
  - When MAX_HOLD≠0 and hold_cnt reaches MAX_HOLD-1 with another req pending, the owner's access that cycle still proceeds.
  - The grant is then revoked at the next edge, preempt[owner] pulses for one cycle, and handover follows the normal rr rule.
  - With no other req pending, ownership continues and hold_cnt saturates.
- A non-owner's req_we, req_addr and req_wdata are ignored. When no access is issued, bram_en=0, bram_we=0, bram_addr=0, bram_wdata=0.
- Read return: a RD_LATENCY-deep shift register carries the one-hot requester ID of each issued read. rvalid[i] is high exactly RD_LATENCY cycles after the issue cycle.
  - Delivery still goes to requester i if its grant was released or preempted in between.
- busy = (state==OWNED) | (any in-flight read tag).

## Timing
- Reset values: gnt=0, preempt=0, rvalid=0, busy=0, bram_en=0, bram_we=0, rr_ptr=0, hold_cnt=0, state=IDLE, all pipeline tags cleared.
- Reset mid-burst discards in-flight reads; no rvalid is produced for them.
- Grant latency: req rises in cycle t with the port free → gnt high in t+1 → first access in t+1.
- Read data latency: address issued in t → rvalid and rdata valid in t+RD_LATENCY.
- Throughput: one access per cycle while owned. Handover costs one non-access cycle, the cycle in which the old owner's req is low.
- Simultaneous requests: lowest index at or after rr_ptr wins. After reset, requester 0 has priority.

## Test plan
- Single reader, RD_LATENCY=1: req[1] high for 4 cycles with addresses 0..3 → gnt[1] one cycle after req, bram_addr 0,1,2,3, rvalid[1] for 4 cycles starting one cycle after the first address, rdata = preloaded words.
- Contention after reset: req[0] and req[2] rise together → gnt[0] first. After req[0] drops, gnt[2] in the next cycle and rr_ptr=1. Re-raise both → gnt[2] is kept until it releases, then gnt[0].
- Write then read, requester 3: writes 0xDEADBEEF to addr 100, releases, reads addr 100 → rvalid[3] with rdata=0xDEADBEEF. No rvalid on the write.
- Preemption, MAX_HOLD=8: req[0] held indefinitely, req[1] rises at cycle 2 → gnt[0] drops after 8 accesses, preempt[0] pulses for one cycle, gnt[1] rises at the same edge. A read issued in the last owned cycle still gets rvalid[0].
- RD_LATENCY=3 handover: the last read of requester 0 is followed by requester 1's reads → rvalid[0] and rvalid[1] are never high together, each 3 cycles after its issue.
- Async reset: assert rst mid-burst with 2 reads in flight → all outputs go to reset values immediately, with no rvalid after deassertion.
